// File: rtl/cfu_pkg.sv
// Shared types and instruction-field positions for the CFU issue/writeback sequencer.
package cfu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } cfu_state_e;

    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;
    localparam int F3_LSB  = 12;
    localparam int F3_MSB  = 14;
    localparam int F7_LSB  = 25;
    localparam int F7_MSB  = 31;

endpackage

// File: rtl/cfu_perf_counter.sv
// 32-bit event counter that wraps from all-ones back to zero.
module cfu_perf_counter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cfu_issue.sv
// Issue/writeback sequencer: holds one custom instruction stable for the CFU,
// pulses its enable, waits out stall and hands the result to writeback.
//   state   | meaning
//   IDLE    | ready for a new instruction
//   EXEC    | CFU operating; enable pulsed in first cycle, waiting on stall
//   WB      | result (or opcode error) offered to writeback
module cfu_issue
    import cfu_pkg::*;
#(
    parameter logic [6:0] OPCODE = OPC_CUSTOM0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] ir_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic        cfu_en_o,
    output logic [2:0]  cfu_funct3_o,
    output logic [6:0]  cfu_funct7_o,
    output logic [31:0] cfu_src1_o,
    output logic [31:0] cfu_src2_o,
    input  logic        cfu_stall_i,
    input  logic [31:0] cfu_rslt_i,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        wb_err_o,
    output logic [31:0] op_count_o,
    output logic [31:0] stall_cycles_o
);

    cfu_state_e  state_q;
    logic        en_q;
    logic [2:0]  funct3_q;
    logic [6:0]  funct7_q;
    logic [31:0] src1_q;
    logic [31:0] src2_q;
    logic [4:0]  rd_q;
    logic        wb_valid_q;
    logic [31:0] wb_data_q;
    logic        wb_err_q;
    logic        op_inc;
    logic        stall_inc;
    logic        unused_ir;

    // Register-index fields are decoded upstream; only funct/rd/opcode matter here.
    assign unused_ir = ^ir_i[24:15];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            funct3_q   <= '0;
            funct7_q   <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        funct3_q <= ir_i[F3_MSB:F3_LSB];
                        funct7_q <= ir_i[F7_MSB:F7_LSB];
                        rd_q     <= ir_i[RD_MSB:RD_LSB];
                        src1_q   <= rs1_data_i;
                        src2_q   <= rs2_data_i;
                        if (ir_i[OPC_MSB:OPC_LSB] == OPCODE) begin
                            state_q  <= ST_EXEC;
                            en_q     <= 1'b1;
                            wb_err_q <= 1'b0;
                        end else begin
                            state_q    <= ST_WB;
                            wb_valid_q <= 1'b1;
                            wb_err_q   <= 1'b1;
                            wb_data_q  <= '0;
                        end
                    end
                end
                ST_EXEC: begin
                    en_q <= 1'b0;
                    if (!cfu_stall_i) begin
                        wb_data_q  <= cfu_rslt_i;
                        wb_valid_q <= 1'b1;
                        state_q    <= ST_WB;
                    end
                end
                ST_WB: begin
                    if (wb_ready_i) begin
                        wb_valid_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign op_inc    = (state_q == ST_WB) && wb_ready_i && !wb_err_q;
    assign stall_inc = (state_q == ST_EXEC) && cfu_stall_i;

    cfu_perf_counter u_op_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (op_inc),
        .cnt_o (op_count_o)
    );

    cfu_perf_counter u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall_inc),
        .cnt_o (stall_cycles_o)
    );

    assign req_ready_o  = (state_q == ST_IDLE);
    assign cfu_en_o     = en_q;
    assign cfu_funct3_o = funct3_q;
    assign cfu_funct7_o = funct7_q;
    assign cfu_src1_o   = src1_q;
    assign cfu_src2_o   = src2_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_rd_o      = rd_q;
    assign wb_data_o    = wb_data_q;
    assign wb_err_o     = wb_err_q;

endmodule

// File: tb/tb_cfu_issue.sv
// Bench for cfu_issue: CFU model (rslt = src1|src2, programmable stall) and a
// writeback scoreboard fed at accept time.
module tb_cfu_issue;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] ir_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        cfu_en_o;
    logic [2:0]  cfu_funct3_o;
    logic [6:0]  cfu_funct7_o;
    logic [31:0] cfu_src1_o;
    logic [31:0] cfu_src2_o;
    logic        cfu_stall_i;
    logic [31:0] cfu_rslt_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        wb_err_o;
    logic [31:0] op_count_o;
    logic [31:0] stall_cycles_o;

    always #5 clk_i = ~clk_i;

    cfu_issue dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .ir_i           (ir_i),
        .rs1_data_i     (rs1_data_i),
        .rs2_data_i     (rs2_data_i),
        .cfu_en_o       (cfu_en_o),
        .cfu_funct3_o   (cfu_funct3_o),
        .cfu_funct7_o   (cfu_funct7_o),
        .cfu_src1_o     (cfu_src1_o),
        .cfu_src2_o     (cfu_src2_o),
        .cfu_stall_i    (cfu_stall_i),
        .cfu_rslt_i     (cfu_rslt_i),
        .wb_valid_o     (wb_valid_o),
        .wb_ready_i     (wb_ready_i),
        .wb_rd_o        (wb_rd_o),
        .wb_data_o      (wb_data_o),
        .wb_err_o       (wb_err_o),
        .op_count_o     (op_count_o),
        .stall_cycles_o (stall_cycles_o)
    );

    // CFU model: stall held for stall_cfg cycles starting with the enable cycle.
    int stall_cfg = 0;
    int stall_cnt;
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                          stall_cnt <= 0;
        else if (cfu_en_o && stall_cfg > 0) stall_cnt <= stall_cfg - 1;
        else if (stall_cnt > 0)             stall_cnt <= stall_cnt - 1;
    end
    assign cfu_stall_i = (cfu_en_o && stall_cfg > 0) || (stall_cnt > 0);
    assign cfu_rslt_i  = cfu_stall_i ? 32'hDEAD_BEEF : (cfu_src1_o | cfu_src2_o);

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
    } wb_exp_t;

    wb_exp_t     sb_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_ops = '0;
    logic [31:0] exp_stalls = '0;

    // Called at a negedge; drives the request for one edge and returns at the next negedge (cycle 1).
    task automatic accept(input logic [31:0] ir, input logic [31:0] rs1, input logic [31:0] rs2);
        wb_exp_t e;
        ir_i = ir; rs1_data_i = rs1; rs2_data_i = rs2; req_valid_i = 1'b1;
        e.rd   = ir[11:7];
        e.err  = (ir[6:0] != 7'b0001011);
        e.data = e.err ? 32'd0 : (rs1 | rs2);
        sb_q.push_back(e);
        @(negedge clk_i);
        req_valid_i = 1'b0; ir_i = '0; rs1_data_i = '0; rs2_data_i = '0;
    endtask

    // Walks from cycle 1 until wb_valid_o (bounded), recording enable and operand behaviour.
    task automatic run_to_wb(input logic [31:0] s1, input logic [31:0] s2,
                             output int lat, output int en_cnt, output int en_first, output int src_bad);
        lat = 1; en_cnt = 0; en_first = -1; src_bad = 0;
        while (1) begin
            if (cfu_en_o) begin
                en_cnt++;
                if (en_first < 0) en_first = lat;
            end
            if (cfu_src1_o !== s1 || cfu_src2_o !== s2) src_bad++;
            if (wb_valid_o || lat >= 60) break;
            @(negedge clk_i);
            lat++;
        end
    endtask

    task automatic pop_exp(output wb_exp_t e, output bit ok);
        ok = (sb_q.size() != 0);
        e = ok ? sb_q.pop_front() : '0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_valid_i = 1'b0; ir_i = '0; rs1_data_i = '0; rs2_data_i = '0; wb_ready_i = 1'b1;
        #12;
        tests++;
        if ({req_ready_o, cfu_en_o, wb_valid_o, wb_err_o} !== 4'b1000) begin
            fails++; $display("FAIL reset_ctrl got %b want 1000", {req_ready_o, cfu_en_o, wb_valid_o, wb_err_o});
        end
        tests++;
        if ({wb_data_o, wb_rd_o, cfu_funct3_o, cfu_funct7_o, cfu_src1_o, cfu_src2_o, op_count_o, stall_cycles_o} !== '0) begin
            fails++; $display("FAIL reset_data got data=%h rd=%0d src1=%h ops=%0d stalls=%0d want all 0",
                              wb_data_o, wb_rd_o, cfu_src1_o, op_count_o, stall_cycles_o);
        end
        @(negedge clk_i); rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_comb();
        int lat, en_cnt, en_first, src_bad; wb_exp_t e; bit ok;
        logic [31:0] ir2;
        stall_cfg = 0;
        accept(32'h0000_058B, 32'hF0, 32'h0F);
        run_to_wb(32'hF0, 32'h0F, lat, en_cnt, en_first, src_bad);
        pop_exp(e, ok);
        tests++;
        if (lat != 2 || en_cnt != 1 || en_first != 1) begin
            fails++; $display("FAIL comb_timing got lat=%0d en_cnt=%0d en_at=%0d want 2/1/1", lat, en_cnt, en_first);
        end
        tests++;
        if (!ok || wb_data_o !== e.data || wb_rd_o !== e.rd || wb_err_o !== e.err || e.data !== 32'hFF || e.rd !== 5'd11) begin
            fails++; $display("FAIL comb_result got data=%h rd=%0d err=%b want data=000000ff rd=11 err=0", wb_data_o, wb_rd_o, wb_err_o);
        end
        exp_ops++;
        @(negedge clk_i);
        tests++;
        if (op_count_o !== exp_ops || wb_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            fails++; $display("FAIL comb_handshake got ops=%0d valid=%b ready=%b want ops=%0d valid=0 ready=1",
                              op_count_o, wb_valid_o, req_ready_o, exp_ops);
        end
        // Back-to-back issue straight after the handshake, with funct fields populated.
        ir2 = {7'h55, 5'd2, 5'd1, 3'b101, 5'd3, 7'b0001011};
        accept(ir2, 32'h1234_0000, 32'h0000_5678);
        tests++;
        if (cfu_funct3_o !== 3'b101 || cfu_funct7_o !== 7'h55) begin
            fails++; $display("FAIL funct_latch got f3=%b f7=%h want 101/55", cfu_funct3_o, cfu_funct7_o);
        end
        run_to_wb(32'h1234_0000, 32'h0000_5678, lat, en_cnt, en_first, src_bad);
        pop_exp(e, ok);
        tests++;
        if (lat != 2 || !ok || wb_data_o !== e.data || wb_rd_o !== e.rd || wb_err_o !== e.err) begin
            fails++; $display("FAIL back_to_back got lat=%0d data=%h rd=%0d want lat=2 data=%h rd=%0d", lat, wb_data_o, wb_rd_o, e.data, e.rd);
        end
        exp_ops++;
        @(negedge clk_i);
    endtask

    task automatic test_stall();
        int lat, en_cnt, en_first, src_bad; wb_exp_t e; bit ok;
        stall_cfg = 3;
        accept({7'h01, 10'd0, 3'b010, 5'd7, 7'b0001011}, 32'hA5A5_0000, 32'h0000_5A5A);
        run_to_wb(32'hA5A5_0000, 32'h0000_5A5A, lat, en_cnt, en_first, src_bad);
        pop_exp(e, ok);
        exp_stalls = exp_stalls + 32'd3;
        tests++;
        if (lat != 5 || en_cnt != 1 || en_first != 1) begin
            fails++; $display("FAIL stall_timing got lat=%0d en_cnt=%0d en_at=%0d want 5/1/1", lat, en_cnt, en_first);
        end
        tests++;
        if (src_bad != 0 || stall_cycles_o !== exp_stalls) begin
            fails++; $display("FAIL stall_hold got src_bad=%0d stalls=%0d want 0/%0d", src_bad, stall_cycles_o, exp_stalls);
        end
        tests++;
        if (!ok || wb_data_o !== e.data || wb_rd_o !== e.rd) begin
            fails++; $display("FAIL stall_result got data=%h rd=%0d want data=%h rd=%0d", wb_data_o, wb_rd_o, e.data, e.rd);
        end
        exp_ops++;
        @(negedge clk_i);
        stall_cfg = 0;
    endtask

    task automatic test_bad_opcode();
        int lat, en_cnt, en_first, src_bad; wb_exp_t e; bit ok;
        accept(32'h0020_81B3, 32'h1111_1111, 32'h2222_2222);
        run_to_wb(32'h1111_1111, 32'h2222_2222, lat, en_cnt, en_first, src_bad);
        pop_exp(e, ok);
        tests++;
        if (lat != 1 || en_cnt != 0) begin
            fails++; $display("FAIL bad_op_timing got lat=%0d en_cnt=%0d want 1/0", lat, en_cnt);
        end
        tests++;
        if (!ok || wb_err_o !== 1'b1 || e.err !== 1'b1 || wb_data_o !== 32'd0 || wb_rd_o !== e.rd) begin
            fails++; $display("FAIL bad_op_result got err=%b data=%h rd=%0d want err=1 data=0 rd=%0d", wb_err_o, wb_data_o, wb_rd_o, e.rd);
        end
        @(negedge clk_i);
        tests++;
        if (op_count_o !== exp_ops || cfu_en_o !== 1'b0) begin
            fails++; $display("FAIL bad_op_count got ops=%0d en=%b want ops=%0d en=0", op_count_o, cfu_en_o, exp_ops);
        end
    endtask

    task automatic test_backpressure();
        int lat, en_cnt, en_first, src_bad, hold_bad; wb_exp_t e; bit ok;
        wb_ready_i = 1'b0;
        accept({7'h00, 10'd0, 3'b000, 5'd20, 7'b0001011}, 32'h0F0F_0000, 32'h0000_00F0);
        run_to_wb(32'h0F0F_0000, 32'h0000_00F0, lat, en_cnt, en_first, src_bad);
        pop_exp(e, ok);
        hold_bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (wb_valid_o !== 1'b1 || wb_data_o !== e.data || wb_rd_o !== e.rd || req_ready_o !== 1'b0) hold_bad++;
            if (i < 3) @(negedge clk_i);
        end
        tests++;
        if (!ok || lat != 2 || hold_bad != 0) begin
            fails++; $display("FAIL bp_hold got lat=%0d hold_bad=%0d data=%h want lat=2 hold_bad=0 data=%h", lat, hold_bad, wb_data_o, e.data);
        end
        wb_ready_i = 1'b1;
        @(negedge clk_i);
        exp_ops++;
        tests++;
        if (req_ready_o !== 1'b1 || wb_valid_o !== 1'b0 || op_count_o !== exp_ops) begin
            fails++; $display("FAIL bp_release got ready=%b valid=%b ops=%0d want 1/0/%0d", req_ready_o, wb_valid_o, op_count_o, exp_ops);
        end
        accept({7'h00, 10'd0, 3'b000, 5'd21, 7'b0001011}, 32'h0000_0001, 32'h8000_0000);
        run_to_wb(32'h0000_0001, 32'h8000_0000, lat, en_cnt, en_first, src_bad);
        pop_exp(e, ok);
        tests++;
        if (lat != 2 || !ok || wb_data_o !== e.data || wb_rd_o !== e.rd) begin
            fails++; $display("FAIL bp_resume got lat=%0d data=%h want lat=2 data=%h", lat, wb_data_o, e.data);
        end
        exp_ops++;
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid_exec();
        int lat, en_cnt, en_first, src_bad, stray; wb_exp_t e; bit ok;
        stall_cfg = 5;
        accept({7'h00, 10'd0, 3'b000, 5'd9, 7'b0001011}, 32'hCAFE_0000, 32'h0000_BABE);
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        exp_ops = '0; exp_stalls = '0;
        sb_q.delete();
        tests++;
        if ({req_ready_o, cfu_en_o, wb_valid_o, wb_err_o} !== 4'b1000 ||
            {wb_data_o, wb_rd_o, cfu_src1_o, cfu_src2_o, cfu_funct3_o, cfu_funct7_o, op_count_o, stall_cycles_o} !== '0) begin
            fails++; $display("FAIL rst_async got ready=%b en=%b valid=%b src1=%h ops=%0d stalls=%0d want reset values",
                              req_ready_o, cfu_en_o, wb_valid_o, cfu_src1_o, op_count_o, stall_cycles_o);
        end
        @(negedge clk_i); rst_i = 1'b0; stall_cfg = 0;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            if (wb_valid_o !== 1'b0) stray++;
            @(negedge clk_i);
        end
        tests++;
        if (stray != 0) begin
            fails++; $display("FAIL rst_no_wb got %0d valid cycles want 0", stray);
        end
        accept({7'h00, 10'd0, 3'b000, 5'd5, 7'b0001011}, 32'h0000_00AA, 32'h0000_5500);
        run_to_wb(32'h0000_00AA, 32'h0000_5500, lat, en_cnt, en_first, src_bad);
        pop_exp(e, ok);
        exp_ops++;
        @(negedge clk_i);
        tests++;
        if (lat != 2 || !ok || e.data !== 32'h0000_55AA || op_count_o !== exp_ops) begin
            fails++; $display("FAIL rst_recover got lat=%0d ops=%0d want lat=2 ops=%0d", lat, op_count_o, exp_ops);
        end
    endtask

    task automatic test_wrap();
        int lat, en_cnt, en_first, src_bad; wb_exp_t e; bit ok;
        dut.u_op_cnt.cnt_q = 32'hFFFF_FFFF;
        exp_ops = 32'hFFFF_FFFF;
        #1;
        tests++;
        if (op_count_o !== exp_ops) begin
            fails++; $display("FAIL wrap_preload got %h want %h", op_count_o, exp_ops);
        end
        @(negedge clk_i);
        accept({7'h00, 10'd0, 3'b000, 5'd1, 7'b0001011}, 32'h3, 32'h4);
        run_to_wb(32'h3, 32'h4, lat, en_cnt, en_first, src_bad);
        pop_exp(e, ok);
        exp_ops = exp_ops + 32'd1;
        @(negedge clk_i);
        tests++;
        if (!ok || op_count_o !== exp_ops || exp_ops !== 32'd0) begin
            fails++; $display("FAIL wrap_count got %h want %h", op_count_o, exp_ops);
        end
    endtask

    initial begin
        test_reset();
        test_comb();
        test_stall();
        test_bad_opcode();
        test_backpressure();
        test_reset_mid_exec();
        test_wrap();
        tests++;
        if (sb_q.size() != 0) begin
            fails++; $display("FAIL scoreboard_drain got %0d entries want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
